// File: rtl/branch_fetch_sequencer.sv
// ============================================================================
// branch_fetch_sequencer : PC owner, imem req/valid fetch, IF/ID load, branch redirect/squash.
// Optional macro BRANCH_DELAY_SLOT_EN keeps IF/ID (delay slot) and suppresses flush_d on redirect.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              branchPresent,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [31:0]       branch_offset,
  input  logic              stall_d,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  output logic              ifid_valid,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              flush_d
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       skid_instr;
  logic [ADDR_W-1:0] skid_pc;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target_raw;
  logic [ADDR_W-1:0] target;
  logic              ifid_free;

  assign pc_plus4   = pc + ADDR_W'(4);
  // Word offset is sign-extended to the address width before scaling by 4.
  assign target_raw = branch_pc + ADDR_W'(4)
                    + ADDR_W'({{ADDR_W{branch_offset[31]}}, branch_offset, 2'b00});
  assign target     = {target_raw[ADDR_W-1:2], 2'b00};
  assign ifid_free  = !ifid_valid || !stall_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      flush_d    <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      flush_d <= 1'b0;
      if (state == IDLE) begin
        state    <= FETCH;
        imem_req <= 1'b1;
        if (branchPresent) begin
          pc        <= target;
          imem_addr <= target;
        end else begin
          imem_addr <= pc;
        end
      end else if (branchPresent) begin
        pc         <= target;
        skid_instr <= '0;
        skid_pc    <= '0;
`ifndef BRANCH_DELAY_SLOT_EN
        flush_d    <= 1'b1;
        ifid_valid <= 1'b0;
        ifid_instr <= '0;
`endif
        // A still-outstanding request must complete before the target is fetched.
        if (imem_req && !imem_valid) begin
          state <= DISCARD;
        end else begin
          state     <= FETCH;
          imem_req  <= 1'b1;
          imem_addr <= target;
        end
      end else begin
        case (state)
          FETCH: begin
            if (!imem_req) begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end else if (imem_valid) begin
              imem_req <= 1'b0;
              if (ifid_free) begin
                ifid_valid <= 1'b1;
                ifid_instr <= imem_rdata;
                ifid_pc    <= pc;
                pc         <= pc_plus4;
              end else begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
                state      <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!stall_d) begin
              ifid_valid <= 1'b1;
              ifid_instr <= skid_instr;
              ifid_pc    <= skid_pc;
              pc         <= pc_plus4;
              state      <= FETCH;
            end
          end
          DISCARD: begin
            if (imem_valid) begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
              state     <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_fetch_sequencer.sv
// ============================================================================
// tb_branch_fetch_sequencer : directed bench with a fetch-address scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_fetch_sequencer;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        branchPresent;
  logic [31:0] branch_pc;
  logic [31:0] branch_offset;
  logic        stall_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        flush_d;
  logic        mem_ready;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  logic [31:0] exp_q[$];

  branch_fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .branchPresent (branchPresent),
    .branch_pc     (branch_pc),
    .branch_offset (branch_offset),
    .stall_d       (stall_d),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .flush_d       (flush_d)
  );

  // Zero-wait memory when ready; data is a tagged copy of the address.
  assign imem_valid = imem_req & mem_ready;
  assign imem_rdata = 32'hA500_0000 ^ imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Every completed handshake must match the next expected fetch address.
  always @(negedge clk) begin
    if (reset_n && imem_req && imem_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
      end else begin
        check("sb_fetch_addr", imem_addr, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset_n = 1'b0; branchPresent = 1'b0; branch_pc = '0; branch_offset = '0;
    stall_d = 1'b0; mem_ready = 1'b0;
    cycle(2);
    check("rst_req",   {31'd0, imem_req},   32'd0);
    check("rst_addr",  imem_addr,           32'd0);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_instr", ifid_instr,          32'd0);
    check("rst_pc",    ifid_pc,             32'd0);
    check("rst_flush", {31'd0, flush_d},    32'd0);

    // Sequential fetches with zero-wait memory.
    reset_n = 1'b1;
    cycle(1);
    check("idle_req",  {31'd0, imem_req}, 32'd1);
    check("idle_addr", imem_addr,         32'h0);
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);  exp_q.push_back(32'h10);
    mem_ready = 1'b1;
    cycle(1);
    check("f0_valid", {31'd0, ifid_valid}, 32'd1);
    check("f0_pc",    ifid_pc,             32'h0);
    check("f0_instr", ifid_instr,          mem_word(32'h0));
    check("f0_gap",   {31'd0, imem_req},   32'd0);
    cycle(1);
    check("f1_hold_pc", ifid_pc,   32'h0);
    check("f1_addr",    imem_addr, 32'h4);
    cycle(1);
    check("f1_pc", ifid_pc, 32'h4);
    cycle(2);
    check("f2_pc", ifid_pc, 32'h8);
    cycle(2);
    check("f3_pc", ifid_pc, 32'hC);

    // Stall with a live IF/ID: response at 0x10 parks in the skid buffer.
    stall_d = 1'b1;
    cycle(2);
    check("hold_req",   {31'd0, imem_req}, 32'd0);
    check("hold_pc",    ifid_pc,           32'hC);
    check("hold_instr", ifid_instr,        mem_word(32'hC));
    cycle(2);
    check("hold2_req", {31'd0, imem_req}, 32'd0);
    check("hold2_pc",  ifid_pc,           32'hC);
    cycle(1);
    stall_d = 1'b0;
    cycle(1);
    check("unstall_pc",    ifid_pc,             32'h10);
    check("unstall_instr", ifid_instr,          mem_word(32'h10));
    check("unstall_valid", {31'd0, ifid_valid}, 32'd1);

    // Redirect while a fetch is outstanding.
    mem_ready = 1'b0;
    exp_q.push_back(32'h14); exp_q.push_back(32'h30);
    exp_q.push_back(32'h34); exp_q.push_back(32'h0);
    cycle(1);
    check("out_req",  {31'd0, imem_req}, 32'd1);
    check("out_addr", imem_addr,         32'h14);
    branchPresent = 1'b1; branch_pc = 32'h20; branch_offset = 32'd3;
    cycle(1);
    branchPresent = 1'b0;
    check("br1_flush", {31'd0, flush_d},    {31'd0, !DS});
    check("br1_valid", {31'd0, ifid_valid}, {31'd0, DS});
    check("br1_instr", ifid_instr,          DS ? mem_word(32'h10) : 32'h0);
    check("br1_stale", imem_addr,           32'h14);
    cycle(1);
    check("br1_pulse", {31'd0, flush_d}, 32'd0);
    mem_ready = 1'b1;
    cycle(1);
    check("br1_target", imem_addr,           32'h30);
    check("br1_req",    {31'd0, imem_req},   32'd1);
    check("br1_drop",   {31'd0, ifid_valid}, {31'd0, DS});
    cycle(1);
    check("br1_ld_pc",    ifid_pc,    32'h30);
    check("br1_ld_instr", ifid_instr, mem_word(32'h30));

    // Redirect in the same cycle as imem_valid, negative offset.
    cycle(1);
    check("br2_pre_addr", imem_addr, 32'h34);
    branchPresent = 1'b1; branch_pc = 32'h4; branch_offset = 32'hFFFF_FFFE;
    cycle(1);
    branchPresent = 1'b0;
    check("br2_target", imem_addr,           32'h0);
    check("br2_flush",  {31'd0, flush_d},    {31'd0, !DS});
    check("br2_valid",  {31'd0, ifid_valid}, {31'd0, DS});
    cycle(1);
    check("br2_ld_pc",    ifid_pc,    32'h0);
    check("br2_ld_instr", ifid_instr, mem_word(32'h0));

    // Unaligned branch_pc to the top word, then PC wrap to zero.
    mem_ready = 1'b0;
    exp_q.push_back(32'h4); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    cycle(1);
    check("br3_pre_addr", imem_addr, 32'h4);
    branchPresent = 1'b1; branch_pc = 32'hFFFF_FFF2; branch_offset = 32'd2;
    cycle(1);
    branchPresent = 1'b0;
    mem_ready = 1'b1;
    check("br3_flush", {31'd0, flush_d},    {31'd0, !DS});
    check("br3_valid", {31'd0, ifid_valid}, {31'd0, DS});
    cycle(2);
    check("wrap_ld_pc",    ifid_pc,    32'hFFFF_FFFC);
    check("wrap_ld_instr", ifid_instr, mem_word(32'hFFFF_FFFC));
    cycle(1);
    check("wrap_addr", imem_addr, 32'h0);
    cycle(1);
    mem_ready = 1'b0;
    check("wrap_ld2_pc", ifid_pc, 32'h0);
    cycle(1);
    check("mid_req",  {31'd0, imem_req}, 32'd1);
    check("mid_addr", imem_addr,         32'h4);
    check("sb_drained", exp_q.size(), 32'd0);

    // Asynchronous reset while a fetch is outstanding.
    reset_n = 1'b0;
    #1;
    check("arst_req",   {31'd0, imem_req},   32'd0);
    check("arst_addr",  imem_addr,           32'd0);
    check("arst_valid", {31'd0, ifid_valid}, 32'd0);
    check("arst_instr", ifid_instr,          32'd0);
    check("arst_pc",    ifid_pc,             32'd0);
    check("arst_flush", {31'd0, flush_d},    32'd0);
    cycle(1);
    reset_n = 1'b1;
    cycle(1);
    check("rerun_req",  {31'd0, imem_req}, 32'd1);
    check("rerun_addr", imem_addr,         32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
